// File: rtl/risc_pkg.sv
// Shared types for the decode->execute boundary: forward selects, interlock states
// and the packed EX pipeline register.
package risc_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 12;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b10,
        FWD_MEM = 2'b11
    } fwd_sel_e;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } ilock_state_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [CTRL_W-1:0] ctrl;
        logic              mem_read;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
    } ex_bundle_t;

    localparam ex_bundle_t EX_BUBBLE = '0;

    // The reserved select 01 falls through to the regfile value.
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf_data,
        input logic [XLEN-1:0] mem_data,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] w_res;
        w_res = rf_data;
        if (sel == FWD_MEM)
            w_res = mem_data;
        else if (sel == FWD_WB)
            w_res = wb_data;
        return w_res;
    endfunction

endpackage

// File: rtl/load_use_interlock.sv
// Load-use interlock: holds fetch/decode for LOAD_LAT cycles per hazard and
// requests a bubble into EX; a flush overrides everything.
module load_use_interlock
    import risc_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_hazard,
    input  logic i_flush,
    output logic o_stall_fetch_dec,
    output logic o_insert_bubble
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);

    ilock_state_e     r_state;
    ilock_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking so state and counter update together at the edge.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        o_stall_fetch_dec = 1'b0;
        o_insert_bubble   = 1'b0;
        if (i_flush) begin
            w_state_nxt     = RUN;
            w_cnt_nxt       = '0;
            o_insert_bubble = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_hazard) begin
                        o_stall_fetch_dec = 1'b1;
                        o_insert_bubble   = 1'b1;
                        w_cnt_nxt         = CNT_INIT;
                        w_state_nxt       = (LOAD_LAT > 1) ? STALL : RUN;
                    end
                end
                STALL: begin
                    // The RUN cycle counts as the first stall, so leave when the count runs out.
                    o_stall_fetch_dec = 1'b1;
                    o_insert_bubble   = 1'b1;
                    w_cnt_nxt         = r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dec_ex_stage.sv
// Decode->execute pipeline register with bubble insertion, operand forwarding
// from MEM/WB and the load-use interlock.
module dec_ex_stage
    import risc_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs1_addr,
    input  logic [REG_AW-1:0] dec_rs2_addr,
    input  logic [REG_AW-1:0] dec_rd_addr,
    input  logic [XLEN-1:0]   dec_rs1_data,
    input  logic [XLEN-1:0]   dec_rs2_data,
    input  logic [XLEN-1:0]   dec_imm,
    input  logic [XLEN-1:0]   dec_pc,
    input  logic [CTRL_W-1:0] dec_ctrl,
    input  logic              dec_mem_read,
    input  logic              flush_dec_ex_pipeline,
    input  logic [1:0]        forward_alu_a,
    input  logic [1:0]        forward_alu_b,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs1_addr,
    output logic [REG_AW-1:0] ex_rs2_addr,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic              stall_fetch_dec
);

    ex_bundle_t r_ex;
    ex_bundle_t w_ex_nxt;
    logic       w_hazard;
    logic       w_bubble;

    // A loaded value is not available to the very next instruction; x0 never counts.
    assign w_hazard = r_ex.valid & r_ex.mem_read & (r_ex.rd_addr != '0) & dec_valid
                    & ((dec_rs1_addr == r_ex.rd_addr) | (dec_rs2_addr == r_ex.rd_addr));

    load_use_interlock #(
        .LOAD_LAT (LOAD_LAT)
    ) u_interlock (
        .clk               (clk),
        .rst               (rst),
        .i_hazard          (w_hazard),
        .i_flush           (flush_dec_ex_pipeline),
        .o_stall_fetch_dec (stall_fetch_dec),
        .o_insert_bubble   (w_bubble)
    );

    always_comb begin
        w_ex_nxt = EX_BUBBLE;
        if (!w_bubble) begin
            w_ex_nxt.valid    = dec_valid;
            w_ex_nxt.rs1_addr = dec_rs1_addr;
            w_ex_nxt.rs2_addr = dec_rs2_addr;
            w_ex_nxt.rd_addr  = dec_rd_addr;
            w_ex_nxt.ctrl     = dec_ctrl;
            w_ex_nxt.mem_read = dec_mem_read;
            w_ex_nxt.pc       = dec_pc;
            w_ex_nxt.imm      = dec_imm;
            w_ex_nxt.rs1_data = dec_rs1_data;
            w_ex_nxt.rs2_data = dec_rs2_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ex <= EX_BUBBLE;
        else
            r_ex <= w_ex_nxt;
    end

    assign ex_valid    = r_ex.valid;
    assign ex_rs1_addr = r_ex.rs1_addr;
    assign ex_rs2_addr = r_ex.rs2_addr;
    assign ex_rd_addr  = r_ex.rd_addr;
    assign ex_ctrl     = r_ex.ctrl;
    assign ex_mem_read = r_ex.mem_read;
    assign ex_pc       = r_ex.pc;
    assign ex_imm      = r_ex.imm;

    // Selects driven for an empty slot are meaningless, so they are ignored.
    assign ex_op_a = r_ex.valid ? fwd_mux(forward_alu_a, r_ex.rs1_data, mem_fwd_data, wb_fwd_data)
                                : r_ex.rs1_data;
    assign ex_op_b = r_ex.valid ? fwd_mux(forward_alu_b, r_ex.rs2_data, mem_fwd_data, wb_fwd_data)
                                : r_ex.rs2_data;

endmodule
